// File: rtl/uart_pkg.sv
// Shared UART line-format constants and FSM state encoding (uart_rx / uart_tx).
package uart_pkg;

   localparam int unsigned DATA_BITS            = 8;
   localparam logic        START_BIT            = 1'b0;
   localparam logic        STOP_BIT             = 1'b1;
   localparam int unsigned CLKS_PER_BIT_DEFAULT = 868;

   typedef logic [2:0] uart_state_t;

   localparam uart_state_t ST_IDLE      = 3'd0;
   localparam uart_state_t ST_START     = 3'd1;
   localparam uart_state_t ST_DATA      = 3'd2;
   localparam uart_state_t ST_STOP      = 3'd3;
   localparam uart_state_t ST_WAIT_HIGH = 3'd4;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; resets to RESET_VAL.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, valid/ready output and framing/overrun flags.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
   parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun
);

   localparam int unsigned     CNT_W     = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
   localparam logic [2:0]       LAST_IDX  = 3'(DATA_BITS - 1);

   logic             rx_s;
   uart_state_t      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       data_q, data_d;
   logic             valid_q, valid_d;
   logic             ferr_q, ferr_d;
   logic             ovr_q, ovr_d;
   logic             byte_done;

   sync_2ff #(.RESET_VAL(1'b1)) u_sync (
      .clk_i  (clk),
      .rst_ni (rst),
      .d_i    (rx),
      .q_o    (rx_s)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      shift_d   = shift_q;
      data_d    = data_q;
      valid_d   = valid_q;
      ferr_d    = 1'b0;
      ovr_d     = 1'b0;
      byte_done = 1'b0;

      if (valid_q && rx_ready) valid_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (rx_s == START_BIT) begin
               state_d = ST_START;
               cnt_d   = '0;
            end
         end
         ST_START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d = '0;
               idx_d = '0;
               state_d = (rx_s == START_BIT) ? ST_DATA : ST_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d          = '0;
               shift_d[idx_q] = rx_s;
               if (idx_q == LAST_IDX) state_d = ST_STOP;
               else                   idx_d   = idx_q + 3'd1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d = '0;
               if (rx_s == STOP_BIT) begin
                  state_d   = ST_IDLE;
                  byte_done = 1'b1;
               end else begin
                  state_d = ST_WAIT_HIGH;
                  ferr_d  = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_WAIT_HIGH: begin
            if (rx_s == STOP_BIT) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // A byte may load in the same cycle the previous one is accepted.
      if (byte_done) begin
         if (!valid_q || rx_ready) begin
            data_d  = shift_q;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
      end
   end

   assign rx_data   = data_q;
   assign rx_valid  = valid_q;
   assign frame_err = ferr_q;
   assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;

   localparam int unsigned CPB = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rx  = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       frame_err;
   logic       overrun;

   logic ready_cmd = 1'b0;
   logic bp_en     = 1'b0;

   int unsigned checks = 0;
   int unsigned errors = 0;

   int unsigned ferr_cnt   = 0;
   int unsigned ovr_cnt    = 0;
   int unsigned vrise_cnt  = 0;
   logic        valid_prev = 1'b0;
   logic [7:0]  acc_q[$];
   logic [7:0]  exp_q[$];

   typedef struct {
      logic [7:0]  data;
      logic        stop;
      int unsigned hold;
      int unsigned exp_bytes;
      int unsigned exp_ferr;
   } vec_t;

   vec_t tbl[5];

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   initial forever #5 clk = ~clk;

   // Consumer: ready changes on negedge; a byte counts as accepted when
   // valid&&ready holds going into the next posedge.
   always @(negedge clk) begin
      rx_ready = bp_en ? ($urandom_range(0, 3) != 0) : ready_cmd;
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
      if (rx_valid && !valid_prev) vrise_cnt++;
      valid_prev = rx_valid;
      if (rx_valid && rx_ready) acc_q.push_back(rx_data);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_clks(input int unsigned n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stopv, input int unsigned hold);
      logic [9:0] bits;
      bits = {stopv, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx = bits[i];
         wait_clks(CPB);
      end
      if (hold > 0) begin
         rx = 1'b0;
         wait_clks(hold);
      end
      rx = 1'b1;
   endtask

   initial begin
      int unsigned n;
      int unsigned a0, f0, o0, v0;

      tbl[0] = '{8'h00, 1'b1, 0, 1, 0};
      tbl[1] = '{8'hFF, 1'b1, 0, 1, 0};
      tbl[2] = '{8'h81, 1'b0, 40 * CPB, 0, 1};
      tbl[3] = '{8'h7E, 1'b1, 0, 1, 0};
      tbl[4] = '{8'h5A, 1'b1, 0, 1, 0};

      // Reset state
      wait_clks(3);
      check("reset_rx_data", rx_data, 8'h00);
      check("reset_rx_valid", rx_valid, 1'b0);
      check("reset_frame_err", frame_err, 1'b0);
      check("reset_overrun", overrun, 1'b0);
      rst = 1'b1;
      ready_cmd = 1'b1;
      wait_clks(5);

      // Latency of 0xA5 with ready held high
      f0 = ferr_cnt; o0 = ovr_cnt;
      n = 0;
      fork
         send_frame(8'hA5, 1'b1, 0);
         begin
            while (!rx_valid && n < 400) begin
               @(posedge clk);
               #1;
               n++;
            end
            check("a5_latency", n, 155);
            check("a5_data", rx_data, 8'hA5);
            wait_clks(1);
            check("a5_valid_one_cycle", rx_valid, 1'b0);
         end
      join
      wait_clks(20);
      check("a5_no_ferr", ferr_cnt - f0, 0);
      check("a5_no_ovr", ovr_cnt - o0, 0);

      // Table of single frames, including a break after a bad stop bit
      for (int i = 0; i < 5; i++) begin
         a0 = acc_q.size(); f0 = ferr_cnt;
         send_frame(tbl[i].data, tbl[i].stop, tbl[i].hold);
         wait_clks(20);
         check($sformatf("tbl%0d_bytes", i), acc_q.size() - a0, tbl[i].exp_bytes);
         if (tbl[i].exp_bytes > 0)
            check($sformatf("tbl%0d_data", i), acc_q[acc_q.size() - 1], tbl[i].data);
         check($sformatf("tbl%0d_ferr", i), ferr_cnt - f0, tbl[i].exp_ferr);
      end

      // Short glitch is rejected at the start-bit mid-point
      a0 = acc_q.size(); f0 = ferr_cnt; v0 = vrise_cnt;
      rx = 1'b0;
      wait_clks(5);
      rx = 1'b1;
      wait_clks(40);
      check("glitch_no_valid", vrise_cnt - v0, 0);
      check("glitch_no_ferr", ferr_cnt - f0, 0);
      send_frame(8'h55, 1'b1, 0);
      wait_clks(20);
      check("glitch_then_55_count", acc_q.size() - a0, 1);
      check("glitch_then_55_data", acc_q[acc_q.size() - 1], 8'h55);

      // Overrun while the first byte is held
      ready_cmd = 1'b0;
      wait_clks(2);
      a0 = acc_q.size(); o0 = ovr_cnt; f0 = ferr_cnt;
      send_frame(8'h3C, 1'b1, 0);
      check("ovr_first_valid", rx_valid, 1'b1);
      check("ovr_first_data", rx_data, 8'h3C);
      send_frame(8'hC3, 1'b1, 0);
      wait_clks(10);
      check("ovr_pulse", ovr_cnt - o0, 1);
      check("ovr_data_kept", rx_data, 8'h3C);
      check("ovr_valid_kept", rx_valid, 1'b1);
      check("ovr_no_ferr", ferr_cnt - f0, 0);
      ready_cmd = 1'b1;
      wait_clks(3);
      check("ovr_valid_cleared", rx_valid, 1'b0);
      check("ovr_accepted_count", acc_q.size() - a0, 1);
      check("ovr_accepted_data", acc_q[acc_q.size() - 1], 8'h3C);

      // Reset in the middle of the data bits of 0xFF
      v0 = vrise_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
      fork
         send_frame(8'hFF, 1'b1, 0);
         begin
            wait_clks(60);
            rst = 1'b0;
            #1;
            check("midrst_data", rx_data, 8'h00);
            check("midrst_valid", rx_valid, 1'b0);
            check("midrst_ferr", frame_err, 1'b0);
            check("midrst_ovr", overrun, 1'b0);
            wait_clks(3);
            rst = 1'b1;
         end
      join
      wait_clks(20);
      check("midrst_no_valid", vrise_cnt - v0, 0);
      check("midrst_no_ferr", ferr_cnt - f0, 0);
      check("midrst_no_ovr", ovr_cnt - o0, 0);
      a0 = acc_q.size();
      send_frame(8'h12, 1'b1, 0);
      wait_clks(20);
      check("after_rst_12_count", acc_q.size() - a0, 1);
      check("after_rst_12_data", acc_q[acc_q.size() - 1], 8'h12);

      // Sequential stream with random back-pressure and random gaps
      a0 = acc_q.size(); f0 = ferr_cnt; o0 = ovr_cnt;
      bp_en = 1'b1;
      for (int b = 0; b < 256; b++) begin
         exp_q.push_back(8'(b));
         send_frame(8'(b), 1'b1, 0);
         wait_clks($urandom_range(0, 20));
      end
      n = 0;
      while (acc_q.size() - a0 < exp_q.size() && n < 2000) begin
         wait_clks(1);
         n++;
      end
      bp_en = 1'b0;
      wait_clks(5);
      check("stream_count", acc_q.size() - a0, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         if (a0 + i < acc_q.size())
            check($sformatf("stream_byte%0d", i), acc_q[a0 + i], exp_q[i]);
      end
      check("stream_no_ferr", ferr_cnt - f0, 0);
      check("stream_no_ovr", ovr_cnt - o0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver; the counterpart of the team's uart_tx, sharing the same line format: 8N1, LSB first, idle-high line, 1 start bit (0), 8 data bits, 1 stop bit (1).
- Runs entirely on the system clock with an internal bit-period counter. No derived clock.
- Default 868 clocks per bit gives 115200 baud at 100 MHz.
- Delivers each received byte through a valid/ready handshake to the consumer and flags framing and overrun errors.

Parameters:
- CLKS_PER_BIT, 868, system clocks per bit period; legal range >= 4.
- HALF_BIT, CLKS_PER_BIT/2, clocks from start-edge detection to the start-bit mid-point sample (integer division).

Ports:
- clk  input  1  system clock; all state on posedge
- rst  input  1  asynchronous active-low reset
- rx  input  1  serial line; asynchronous to clk
- rx_data  output  8  received byte; stable while rx_valid=1
- rx_valid  output  1  byte available; held until accepted
- rx_ready  input  1  consumer accepts the byte when rx_valid&&rx_ready at a posedge
- frame_err  output  1  one-cycle pulse: stop bit sampled as 0
- overrun  output  1  one-cycle pulse: byte completed while rx_valid still 1

Behaviour:
- Reset (rst=0, asynchronous):
  - rx_data=0, rx_valid=0, frame_err=0, overrun=0.
  - Synchronizer flops=1, state=IDLE, bit counter=0, bit index=0.
- Synchronizer: 2-flop sync of rx to produce rx_s. All decisions use rx_s only, which adds 2 cycles of input latency.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: when rx_s=0, go to START and clear the counter.
  - START: count to HALF_BIT-1, then sample rx_s.
    - 0: go to DATA, clear the counter, bit index=0.
    - 1: false start (glitch); return to IDLE with no output.
  - DATA: at each CLKS_PER_BIT-1 count, sample rx_s into the shift register at bit[index] (LSB first) and reset the counter. After index 7 is sampled, go to STOP.
  - STOP: at CLKS_PER_BIT-1 count, sample rx_s.
    - 1: byte complete; go to IDLE (a new start may be detected from the next cycle, i.e. half a stop bit early is tolerated).
    - 0: pulse frame_err for 1 cycle, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s=1, then go to IDLE. A break condition produces exactly one frame_err.
- Byte completion, in the cycle after the stop sample:
  - If rx_valid=0, or rx_valid=1 with rx_ready=1 in that same cycle: load rx_data and set rx_valid=1.
  - If rx_valid=1 and rx_ready=0: keep the old byte, drop the new one, pulse overrun for 1 cycle.
- Handshake:
  - rx_valid clears on the posedge where rx_valid&&rx_ready, unless a new byte loads in that same cycle, in which case rx_valid stays 1 with the new data.
  - rx_ready is ignored while rx_valid=0.
- Latency: rx_valid rises 2 (sync) + HALF_BIT + 9*CLKS_PER_BIT + 1 clocks after the falling edge of rx.
- Counter width is clog2(CLKS_PER_BIT). The counter never wraps: it is reset explicitly at every sample.
- Reset mid-frame: immediate return to reset values. The partially received byte is lost and no error is pulsed.

Decomposition:
- Shared package uart_pkg:
  - Frame constants: DATA_BITS=8, START_BIT=1'b0, STOP_BIT=1'b1.
  - Default CLKS_PER_BIT=868.
  - FSM state encoding, which uart_tx reuses for its own states where applicable.
- One natural sub-module, sync_2ff: a 2-flop synchronizer with reset value 1. It is reusable for other asynchronous inputs.

Test Plan (CLKS_PER_BIT=16 in bench; uart_tx instance or a bench driver at the same rate):
- Send 0xA5 with rx_ready=1 -> rx_valid pulses 1 cycle with rx_data=0xA5 at 2+8+144+1 = 155 clocks after the start edge; frame_err=0, overrun=0.
- Send 0x3C then 0xC3 back-to-back with rx_ready=0 -> first byte is held (rx_data=0x3C, rx_valid=1); second completion pulses overrun and rx_data stays 0x3C; raising rx_ready clears rx_valid.
- Drive a 5-clock low glitch on an idle line -> START rejects it at the mid-bit sample; no rx_valid, no frame_err; the FSM returns to IDLE and a following 0x55 is received correctly.
- Send 0x81 with the stop bit forced to 0, then hold the line low for 40 bit times -> exactly one frame_err pulse, no rx_valid; after the line returns high, 0x7E is received correctly.
- Assert rst=0 for 3 clocks mid-DATA of byte 0xFF -> all outputs at reset values immediately and no output for that byte; the next byte 0x12 is received correctly.
- Loopback uart_tx -> uart_rx, both at 868, sending 256 sequential bytes 0x00..0xFF with random rx_ready back-pressure between bytes -> all bytes received in order with no errors.
